// File: rtl/pool1_max2x2.sv
// Streaming 2x2 stride-2 binary max-pool after the first conv layer.
// Per-channel max of binary bits is the OR of the four window bits.
module pool1_max2x2 #(
    parameter int WIDTH  = 26,
    parameter int HEIGHT = 26,
    parameter int CH     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic [CH-1:0] pixel_in,
    output logic [CH-1:0] pool_out,
    output logic          valid_out,
    output logic          frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LD = (WIDTH / 2 > 0) ? WIDTH / 2 : 1;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    // Bottom-right input pixel of the last complete window (floor semantics)
    localparam logic [CW-1:0] FD_COL = CW'(2 * (WIDTH / 2) - 1);
    localparam logic [RW-1:0] FD_ROW = RW'(2 * (HEIGHT / 2) - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CH-1:0] pair_reg;
    logic [CH-1:0] line_buf [LD];
    logic [CH-1:0] hsum;
    logic [LW-1:0] lb_idx;

    assign hsum   = pair_reg | pixel_in;
    assign lb_idx = LW'(col >> 1);

    // Raster position counters; advance only on accepted beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Horizontal pairing, line buffering of top half, and output on bottom half
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_reg   <= '0;
            pool_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < LD; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (!col[0]) begin
                    pair_reg <= pixel_in;
                end else if (!row[0]) begin
                    line_buf[lb_idx] <= hsum;
                end else begin
                    pool_out   <= line_buf[lb_idx] | hsum;
                    valid_out  <= 1'b1;
                    frame_done <= (col == FD_COL) && (row == FD_ROW);
                end
            end
        end
    end

endmodule

// File: tb/tb_pool1_max2x2.sv
// Directed bench for pool1_max2x2: frames driven in raster order,
// pooled outputs compared against hand values and an OR-window model.
module tb_pool1_max2x2;

    localparam int W  = 26;
    localparam int H  = 26;
    localparam int NP = (W / 2) * (H / 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic [7:0] pool_out;
    logic       valid_out;
    logic       frame_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stray_fd = 0;

    logic [7:0] img [2][H][W];
    logic [7:0] exp_v [$];
    int         exp_c [$];
    logic [7:0] got_v [$];
    int         got_c [$];
    bit         got_fd [$];

    pool1_max2x2 #(.WIDTH(W), .HEIGHT(H), .CH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .pixel_in  (pixel_in),
        .pool_out  (pool_out),
        .valid_out (valid_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            got_v.push_back(pool_out);
            got_c.push_back(cyc);
            got_fd.push_back(frame_done === 1'b1);
        end else if (frame_done !== 1'b0) begin
            stray_fd = stray_fd + 1;
        end
    end

    task automatic clear_q();
        exp_v.delete();
        exp_c.delete();
        got_v.delete();
        got_c.delete();
        got_fd.delete();
        stray_fd = 0;
    endtask

    task automatic fill(int f, logic [7:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[f][r][c] = v;
    endtask

    task automatic build_expect(int f);
        for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++)
                exp_v.push_back(img[f][2*pr][2*pc] | img[f][2*pr][2*pc+1] |
                                img[f][2*pr+1][2*pc] | img[f][2*pr+1][2*pc+1]);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            pixel_in = 8'h00;
        end
    endtask

    task automatic send_frame(int f, bit gaps, int nbeats);
        int b;
        b = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (b < nbeats) begin
                    if (gaps) begin
                        while ($urandom_range(0, 1) == 1) idle(1);
                    end
                    @(negedge clk);
                    valid_in = 1'b1;
                    pixel_in = img[f][r][c];
                    if ((r % 2 == 1) && (c % 2 == 1) &&
                        (r < 2 * (H / 2)) && (c < 2 * (W / 2)))
                        exp_c.push_back(cyc + 1);
                end
                b++;
            end
        end
    endtask

    task automatic check_outputs(string name, int nframes);
        int n;
        bit efd;
        idle(4);
        tests++;
        if (got_v.size() !== exp_v.size()) begin
            fails++;
            $display("FAIL %s count: got %0d outputs, expected %0d",
                     name, got_v.size(), exp_v.size());
        end
        tests++;
        if (stray_fd !== 0) begin
            fails++;
            $display("FAIL %s stray_frame_done: got %0d, expected 0", name, stray_fd);
        end
        n = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_v[i] !== exp_v[i]) begin
                fails++;
                $display("FAIL %s value[%0d]: got %02h, expected %02h",
                         name, i, got_v[i], exp_v[i]);
            end
            tests++;
            if (i < exp_c.size() && got_c[i] !== exp_c[i]) begin
                fails++;
                $display("FAIL %s latency[%0d]: got cycle %0d, expected %0d",
                         name, i, got_c[i], exp_c[i]);
            end
            efd = ((i % NP) == NP - 1) && (i < nframes * NP);
            tests++;
            if (got_fd[i] !== efd) begin
                fails++;
                $display("FAIL %s frame_done[%0d]: got %0b, expected %0b",
                         name, i, got_fd[i], efd);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b1;
        pixel_in = 8'hA5;
        repeat (3) @(negedge clk);
        tests++;
        if (pool_out !== 8'h00) begin
            fails++;
            $display("FAIL reset pool_out: got %02h, expected 00", pool_out);
        end
        tests++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("FAIL reset valid_out: got %0b, expected 0", valid_out);
        end
        tests++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset frame_done: got %0b, expected 0", frame_done);
        end
        valid_in = 1'b0;
        pixel_in = 8'h00;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_zero_frame();
        clear_q();
        fill(0, 8'h00);
        build_expect(0);
        send_frame(0, 1'b0, W * H);
        check_outputs("zero_frame", 1);
    endtask

    task automatic test_hot_pixel();
        clear_q();
        fill(0, 8'h00);
        img[0][2][3] = 8'h01;
        build_expect(0);
        send_frame(0, 1'b0, W * H);
        check_outputs("hot_pixel", 1);
        tests++;
        if (got_v.size() < 15 || got_v[14] !== 8'h01) begin
            fails++;
            $display("FAIL hot_pixel idx14: got %02h, expected 01",
                     (got_v.size() > 14) ? got_v[14] : 8'hxx);
        end
        tests++;
        if (got_v.size() < 14 || got_v[13] !== 8'h00) begin
            fails++;
            $display("FAIL hot_pixel idx13: got %02h, expected 00",
                     (got_v.size() > 13) ? got_v[13] : 8'hxx);
        end
    endtask

    task automatic test_channels();
        clear_q();
        fill(0, 8'h00);
        img[0][0][0] = 8'h11;
        img[0][0][1] = 8'h22;
        img[0][1][0] = 8'h44;
        img[0][1][1] = 8'h88;
        build_expect(0);
        send_frame(0, 1'b0, W * H);
        check_outputs("channels", 1);
        tests++;
        if (got_v.size() < 1 || got_v[0] !== 8'hFF) begin
            fails++;
            $display("FAIL channels first: got %02h, expected ff",
                     (got_v.size() > 0) ? got_v[0] : 8'hxx);
        end
        tests++;
        if (got_v.size() < 2 || got_v[1] !== 8'h00) begin
            fails++;
            $display("FAIL channels second: got %02h, expected 00",
                     (got_v.size() > 1) ? got_v[1] : 8'hxx);
        end
    endtask

    task automatic test_random_gaps();
        clear_q();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[0][r][c] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        build_expect(0);
        send_frame(0, 1'b1, W * H);
        check_outputs("random_gaps", 1);
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[0][r][c] = 8'($urandom) & 8'($urandom);
                img[1][r][c] = ~img[0][r][c];
            end
        build_expect(0);
        build_expect(1);
        send_frame(0, 1'b0, W * H);
        send_frame(1, 1'b0, W * H);
        check_outputs("back_to_back", 2);
    endtask

    task automatic test_mid_reset();
        clear_q();
        fill(0, 8'hFF);
        send_frame(0, 1'b0, 300);
        @(negedge clk);
        rst_n = 1'b0;
        valid_in = 1'b1;
        pixel_in = 8'hFF;
        @(negedge clk);
        tests++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset valid_out: got %0b, expected 0", valid_out);
        end
        rst_n = 1'b1;
        valid_in = 1'b0;
        pixel_in = 8'h00;
        clear_q();
        fill(0, 8'h00);
        build_expect(0);
        send_frame(0, 1'b0, W * H);
        check_outputs("mid_reset", 1);
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_hot_pixel();
        test_channels();
        test_random_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
